// File: rtl/block_pixel_shader.sv
// Pixel shader for the 10x20 playfield: maps scan position to a board cell, reads its
// style from board RAM and emits a registered 12-bit colour, with a per-frame palette shadow and level-up flash.
module block_pixel_shader #(
  parameter int unsigned BOARD_X0     = 240,
  parameter int unsigned BOARD_Y0     = 80,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        FRAME_START,
  input  logic [9:0]  DRAW_X,
  input  logic [9:0]  DRAW_Y,
  input  logic [2:0]  LEVEL,
  input  logic [11:0] COLOR_0,
  input  logic [11:0] COLOR_1,
  input  logic [11:0] COLOR_2,
  input  logic [11:0] COLOR_3,
  output logic [7:0]  BOARD_ADDR,
  input  logic [1:0]  BOARD_DATA,
  output logic [3:0]  RED,
  output logic [3:0]  GREEN,
  output logic [3:0]  BLUE,
  output logic        FLASHING
);

  localparam int unsigned COORD_W    = 10;
  localparam int unsigned SUB_W      = 4;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned RGB_W      = 12;
  localparam int unsigned BOARD_COLS = 10;
  localparam int unsigned BOARD_W_PX = 160;
  localparam int unsigned BOARD_H_PX = 320;

  typedef enum logic {ST_IDLE, ST_FLASH} state_t;

  // Stage 1: board mapping
  logic [COORD_W-1:0] w_dx, w_dy;
  logic               w_in_board;
  logic [3:0]         w_col;
  logic [4:0]         w_row;
  logic [ADDR_W-1:0]  w_addr;

  assign w_dx       = DRAW_X - COORD_W'(BOARD_X0);
  assign w_dy       = DRAW_Y - COORD_W'(BOARD_Y0);
  assign w_in_board = (DRAW_X >= COORD_W'(BOARD_X0)) && (w_dx < COORD_W'(BOARD_W_PX)) &&
                      (DRAW_Y >= COORD_W'(BOARD_Y0)) && (w_dy < COORD_W'(BOARD_H_PX));
  assign w_col      = 4'(w_dx >> SUB_W);
  assign w_row      = 5'(w_dy >> SUB_W);
  assign w_addr     = (ADDR_W'(w_row) * ADDR_W'(BOARD_COLS)) + ADDR_W'(w_col);

  logic [ADDR_W-1:0] r_board_addr;
  logic              r_in1, r_in2;
  logic [SUB_W-1:0]  r_sx1, r_sy1, r_sx2, r_sy2;
  logic [1:0]        r_style2;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_board_addr <= '0;
      r_in1        <= 1'b0;
      r_sx1        <= '0;
      r_sy1        <= '0;
      r_in2        <= 1'b0;
      r_sx2        <= '0;
      r_sy2        <= '0;
      r_style2     <= '0;
    end else begin
      r_board_addr <= w_in_board ? w_addr : '0;
      r_in1        <= w_in_board;
      r_sx1        <= SUB_W'(w_dx);
      r_sy1        <= SUB_W'(w_dy);
      r_in2        <= r_in1;
      r_sx2        <= r_sx1;
      r_sy2        <= r_sy1;
      r_style2     <= BOARD_DATA;
    end
  end

  assign BOARD_ADDR = r_board_addr;

  // Palette shadow, captured once per frame
  logic [RGB_W-1:0] r_sh0, r_sh1, r_sh2, r_sh3;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sh0 <= '0;
      r_sh1 <= '0;
      r_sh2 <= '0;
      r_sh3 <= '0;
    end else if (FRAME_START) begin
      r_sh0 <= COLOR_0;
      r_sh1 <= COLOR_1;
      r_sh2 <= COLOR_2;
      r_sh3 <= COLOR_3;
    end
  end

  // Flash FSM
  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_dec;
  logic [2:0]       r_last_level, w_last_level_nx;

  assign w_cnt_dec = r_cnt - CNT_W'(1);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_level <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_last_level <= w_last_level_nx;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_cnt_nx        = r_cnt;
    w_last_level_nx = r_last_level;
    if (FRAME_START) begin
      if (LEVEL != r_last_level) begin
        w_last_level_nx = LEVEL;
        w_cnt_nx        = CNT_W'(FLASH_FRAMES);
        w_state_nx      = ST_FLASH;
      end else if (r_state == ST_FLASH) begin
        w_cnt_nx = w_cnt_dec;
        if (w_cnt_dec == '0) begin
          w_state_nx = ST_IDLE;
        end
      end
    end
  end

  assign FLASHING = (r_state == ST_FLASH);

  // Stage 3: colour select from cell style and sub-cell position
  logic             w_outline, w_hilite, w_rim;
  logic [RGB_W-1:0] w_pixel;

  assign w_outline = (r_sx2 == 4'd15) || (r_sy2 == 4'd15);
  assign w_hilite  = ((r_sx2 == 4'd1) || (r_sx2 == 4'd2)) && ((r_sy2 == 4'd1) || (r_sy2 == 4'd2));
  assign w_rim     = (r_sx2 == 4'd0) || (r_sx2 == 4'd14) || (r_sy2 == 4'd0) || (r_sy2 == 4'd14);

  always_comb begin
    w_pixel = BG_COLOR;
    if (r_in2 && (r_style2 != 2'd0)) begin
      if (w_outline) begin
        w_pixel = r_sh2;
      end else if ((r_state == ST_FLASH) && r_cnt[0]) begin
        w_pixel = r_sh3;
      end else begin
        case (r_style2)
          2'd1:    w_pixel = w_hilite ? r_sh3 : r_sh0;
          2'd2:    w_pixel = w_hilite ? r_sh3 : r_sh1;
          default: w_pixel = w_rim ? r_sh0 : r_sh3;
        endcase
      end
    end
  end

  logic [RGB_W-1:0] r_rgb;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_pixel;
    end
  end

  assign RED   = r_rgb[11:8];
  assign GREEN = r_rgb[7:4];
  assign BLUE  = r_rgb[3:0];

endmodule

// File: tb/tb_block_pixel_shader.sv
// Directed bench for block_pixel_shader: mapping/style table plus flash, palette and reset sequences.
module tb_block_pixel_shader;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        FRAME_START;
  logic [9:0]  DRAW_X, DRAW_Y;
  logic [2:0]  LEVEL;
  logic [11:0] COLOR_0, COLOR_1, COLOR_2, COLOR_3;
  logic [7:0]  BOARD_ADDR;
  logic [1:0]  BOARD_DATA;
  logic [3:0]  RED, GREEN, BLUE;
  logic        FLASHING;

  int checks = 0;
  int errors = 0;

  block_pixel_shader dut (
    .CLK(CLK), .RESET_N(RESET_N), .FRAME_START(FRAME_START),
    .DRAW_X(DRAW_X), .DRAW_Y(DRAW_Y), .LEVEL(LEVEL),
    .COLOR_0(COLOR_0), .COLOR_1(COLOR_1), .COLOR_2(COLOR_2), .COLOR_3(COLOR_3),
    .BOARD_ADDR(BOARD_ADDR), .BOARD_DATA(BOARD_DATA),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .FLASHING(FLASHING)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [1:0]  v;
    logic [7:0]  addr;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one pixel, check address after one edge and colour after three
  task automatic pixel(input logic [9:0] x, input logic [9:0] y, input logic [1:0] v,
                       input logic [7:0] exp_addr, input logic [11:0] exp_rgb, input string name);
    @(negedge CLK);
    DRAW_X = x; DRAW_Y = y; BOARD_DATA = v;
    @(negedge CLK);
    chk({name, "_addr"}, {4'h0, BOARD_ADDR}, {4'h0, exp_addr});
    @(negedge CLK);
    @(negedge CLK);
    chk({name, "_rgb"}, {RED, GREEN, BLUE}, exp_rgb);
  endtask

  task automatic frame_start();
    @(negedge CLK);
    FRAME_START = 1'b1;
    @(negedge CLK);
    FRAME_START = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_cnt;

    vecs[0]  = '{10'd245, 10'd85,  2'd1, 8'd0,   12'h4cf};
    vecs[1]  = '{10'd399, 10'd399, 2'd2, 8'd199, 12'ha52};
    vecs[2]  = '{10'd400, 10'd85,  2'd1, 8'd0,   12'h000};
    vecs[3]  = '{10'd240, 10'd80,  2'd3, 8'd0,   12'h4cf};
    vecs[4]  = '{10'd261, 10'd101, 2'd3, 8'd11,  12'hfff};
    vecs[5]  = '{10'd257, 10'd82,  2'd1, 8'd1,   12'hfff};
    vecs[6]  = '{10'd258, 10'd83,  2'd2, 8'd1,   12'h05f};
    vecs[7]  = '{10'd254, 10'd80,  2'd3, 8'd0,   12'h4cf};
    vecs[8]  = '{10'd300, 10'd200, 2'd0, 8'd73,  12'h000};
    vecs[9]  = '{10'd239, 10'd100, 2'd1, 8'd0,   12'h000};
    vecs[10] = '{10'd300, 10'd400, 2'd1, 8'd0,   12'h000};
    vecs[11] = '{10'd250, 10'd95,  2'd2, 8'd0,   12'ha52};
    vecs[12] = '{10'd399, 10'd80,  2'd1, 8'd9,   12'ha52};
    vecs[13] = '{10'd241, 10'd399, 2'd3, 8'd190, 12'ha52};
    vecs[14] = '{10'd250, 10'd90,  2'd3, 8'd0,   12'hfff};

    RESET_N = 1'b0; FRAME_START = 1'b0; DRAW_X = 10'd245; DRAW_Y = 10'd85;
    LEVEL = 3'd0; BOARD_DATA = 2'd1;
    COLOR_0 = 12'h4cf; COLOR_1 = 12'h05f; COLOR_2 = 12'h000; COLOR_3 = 12'hfff;
    repeat (3) @(negedge CLK);
    chk("reset_rgb", {RED, GREEN, BLUE}, 12'h000);
    chk("reset_addr", {4'h0, BOARD_ADDR}, 12'h000);
    chk("reset_flashing", {11'h0, FLASHING}, 12'h000);
    RESET_N = 1'b1;

    // Shadow still zero until the first frame strobe
    pixel(10'd245, 10'd85, 2'd1, 8'd0, 12'h000, "pre_frame");

    frame_start();
    pixel(10'd245, 10'd85, 2'd1, 8'd0, 12'h4cf, "style1_body");
    pixel(10'd399, 10'd399, 2'd2, 8'd199, 12'h000, "outline_corner");
    pixel(10'd400, 10'd85, 2'd1, 8'd0, 12'h000, "outside_right");

    // Distinct outline colour for the table
    COLOR_2 = 12'ha52;
    frame_start();
    chk("no_flash_same_level", {11'h0, FLASHING}, 12'h000);
    for (int i = 0; i < 15; i++) begin
      pixel(vecs[i].x, vecs[i].y, vecs[i].v, vecs[i].addr, vecs[i].rgb, $sformatf("vec%0d", i));
    end

    // Level-up flash over 8 frames
    COLOR_0 = 12'h8d0; COLOR_1 = 12'h0a0;
    LEVEL = 3'd1;
    frame_start();
    exp_cnt = 8'd8;
    for (int f = 0; f < 8; f++) begin
      chk($sformatf("flash_on_f%0d", f), {11'h0, FLASHING}, 12'h001);
      pixel(10'd245, 10'd85, 2'd1, 8'd0, exp_cnt[0] ? 12'hfff : 12'h8d0, $sformatf("flash_s1_f%0d", f));
      pixel(10'd245, 10'd85, 2'd2, 8'd0, exp_cnt[0] ? 12'hfff : 12'h0a0, $sformatf("flash_s2_f%0d", f));
      if (f == 1) begin
        pixel(10'd399, 10'd399, 2'd2, 8'd199, 12'ha52, "flash_outline");
        pixel(10'd300, 10'd200, 2'd0, 8'd73, 12'h000, "flash_empty");
      end
      frame_start();
      exp_cnt = exp_cnt - 8'd1;
    end
    chk("flash_done", {11'h0, FLASHING}, 12'h000);
    pixel(10'd245, 10'd85, 2'd1, 8'd0, 12'h8d0, "after_flash");

    // Restart on a second level change at frame 3
    LEVEL = 3'd2;
    frame_start();
    repeat (3) frame_start();
    pixel(10'd245, 10'd85, 2'd1, 8'd0, 12'hfff, "restart_pre_odd");
    LEVEL = 3'd3;
    frame_start();
    chk("restart_on", {11'h0, FLASHING}, 12'h001);
    pixel(10'd245, 10'd85, 2'd1, 8'd0, 12'h8d0, "restart_even");
    repeat (7) frame_start();
    chk("restart_still_on", {11'h0, FLASHING}, 12'h001);
    frame_start();
    chk("restart_done", {11'h0, FLASHING}, 12'h000);

    // Palette changes take effect only at the next frame
    COLOR_0 = 12'h123;
    pixel(10'd245, 10'd85, 2'd1, 8'd0, 12'h8d0, "midframe_hold");
    frame_start();
    pixel(10'd245, 10'd85, 2'd1, 8'd0, 12'h123, "midframe_new");

    // Asynchronous reset in the middle of a flash
    LEVEL = 3'd4;
    frame_start();
    chk("flash_before_reset", {11'h0, FLASHING}, 12'h001);
    DRAW_X = 10'd399; DRAW_Y = 10'd399; BOARD_DATA = 2'd1;
    repeat (3) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("async_rst_flashing", {11'h0, FLASHING}, 12'h000);
    chk("async_rst_rgb", {RED, GREEN, BLUE}, 12'h000);
    chk("async_rst_addr", {4'h0, BOARD_ADDR}, 12'h000);
    @(negedge CLK);
    RESET_N = 1'b1;
    pixel(10'd245, 10'd85, 2'd1, 8'd0, 12'h000, "post_reset_shadow");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_pixel_shader.md
# block_pixel_shader

Pixel-side consumer of the level palette. It sits between the VGA timing generator and the RGB pins. It maps each scan position onto the 10x20 playfield, reads the cell style from board RAM, and selects one of the four level colours per pixel. The result is a registered 12-bit RGB pixel. It also latches the palette once per frame and drives a level-up flash sequence.

## Interface
Parameters:
- BOARD_X0, 240, left pixel column of the playfield
- BOARD_Y0, 80, top pixel row of the playfield
- BG_COLOR, 12'h000, colour for empty cells and for pixels outside the board
- FLASH_FRAMES, 8, number of frames in the level-up flash (even, 2..254)

Ports:
- CLK  in  1  pixel clock; all logic is on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- FRAME_START  in  1  one-cycle strobe at the start of vertical blanking
- DRAW_X  in  10  current pixel column
- DRAW_Y  in  10  current pixel row
- LEVEL  in  3  current game level
- COLOR_0..COLOR_3  in  12 each  level palette colours {R,G,B}, 4 bits each
- BOARD_ADDR  out  8  board RAM read address, row*10+col, range 0..199
- BOARD_DATA  in  2  cell style from board RAM, returned one clock after BOARD_ADDR (0 = empty)
- RED, GREEN, BLUE  out  4 each  registered pixel colour
- FLASHING  out  1  high while the flash sequence is active

## Operation
- Board mapping:
  - Cells are 16x16 px. col = (DRAW_X-BOARD_X0)>>4, row = (DRAW_Y-BOARD_Y0)>>4. Subtraction is 10-bit unsigned.
  - in_board = DRAW_X in [BOARD_X0, BOARD_X0+159] and DRAW_Y in [BOARD_Y0, BOARD_Y0+319].
  - sx and sy are the low 4 bits of the offsets.
  - When not in_board, BOARD_ADDR = 0 and the pixel is BG_COLOR.
- Palette shadow: on FRAME_START, SH0..SH3 capture COLOR_0..COLOR_3. Pixels use only the shadow values, so a mid-frame palette change is never visible until the next frame.
- Pixel select, given in_board and style v=BOARD_DATA:
  - v=0: BG_COLOR.
  - sx=15 or sy=15: SH2 (outline). This applies to all v≠0.
  - v=1: highlight SH3 when sx,sy ∈ {1,2}; otherwise SH0.
  - v=2: highlight SH3 when sx,sy ∈ {1,2}; otherwise SH1.
  - v=3: SH0 when sx ∈ {0,14} or sy ∈ {0,14}; otherwise SH3.
- Flash FSM, with states IDLE and FLASH, an 8-bit counter CNT, and a register LAST_LEVEL:
  - On FRAME_START, if LEVEL≠LAST_LEVEL: LAST_LEVEL←LEVEL, CNT←FLASH_FRAMES, state←FLASH. A change during FLASH restarts the count.
  - In FLASH, on FRAME_START with no level change: CNT←CNT-1. If the result is 0, state←IDLE.
  - While in FLASH with CNT[0]=1, every in-board non-empty pixel outputs SH3. Outline, empty and outside pixels are unchanged.
  - FLASHING = (state==FLASH).
- Reset values: RED=GREEN=BLUE=0, BOARD_ADDR=0, FLASHING=0, state=IDLE, CNT=0, LAST_LEVEL=0, SH0..SH3=0. Reset mid-flash aborts to IDLE immediately.

## Timing
- Three-stage pipeline. It advances every clock and has no stall.
  - Edge 1 after DRAW_X/Y are applied: BOARD_ADDR, in_board, sx and sy are registered.
  - Edge 2: BOARD_DATA is sampled, together with the delayed in_board/sx/sy.
  - Edge 3: RED/GREEN/BLUE are updated.
- Pixel latency is 3 clocks from DRAW_X/Y to RGB. The VGA timing generator must delay HS/VS/blank by 3 clocks to match.
- Shadow and flash update cycle: when FRAME_START is high, pixels in the pipeline during that same cycle use the pre-update shadow and flash state. The new values apply from the next cycle.
- The flash phase (CNT[0]) changes only on FRAME_START. Each frame therefore shows a constant phase.

## Test plan
- Reset: assert RESET_N=0 mid-stream -> RGB=0, BOARD_ADDR=0, FLASHING=0 asynchronously. After release, RGB stays 0 for in-board non-empty cells until the first FRAME_START.
- Style 1 body:
  - Setup: level 0 palette (4cf,05f,000,fff) captured by FRAME_START; BOARD_DATA=1.
  - Stimulus: pixel (245,85).
  - Response: BOARD_ADDR=0 one clock later; RGB=4,c,f three clocks later.
- Outline and addressing: pixel (399,399) -> BOARD_ADDR=199. With style 2, RGB=000. Pixel (400,85) -> BG_COLOR and BOARD_ADDR=0.
- Style 3: pixel sx=0 -> SH0. Pixel sx=5, sy=5 -> SH3 (fff).
- Level flash:
  - Change LEVEL 0->1, then pulse FRAME_START.
  - Response: FLASHING=1 for exactly 8 frames. Non-empty in-board pixels are fff on frames with odd CNT and 8d0/0a0 otherwise. FLASHING returns to 0 on the 8th subsequent FRAME_START.
  - A second level change at frame 3 restarts the count at 8.
- Mid-frame palette change: change COLOR_0 without FRAME_START -> output unchanged. After FRAME_START -> the new colour appears.
